// File: rtl/dmem_access_unit_if.sv
// Data-memory bus: one valid/ready request channel with read data returned on the ready cycle.
interface dmem_access_unit_if;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ready,
        input  bus_rdata
    );

    modport slave (
        input  bus_valid,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ready,
        output bus_rdata
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Load/store stage between the datapath and the data-memory bus: lane steering, load
// extension, misalignment rejection and a bus watchdog, stalling the datapath while busy.
module dmem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_req,
    input  logic               mem_we,
    input  logic [1:0]         size,
    input  logic               sign_ext,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               stall,
    output logic               err,
    dmem_access_unit_if.master dbus
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [WD_W-1:0] wd_cnt;
    logic            misalign_c;
    logic            start_c;
    logic            wd_expire_c;

    logic [1:0]      size_p0;
    logic            sext_p0;
    logic [1:0]      off_p0;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = off[0];
            2'b10:   is_misaligned = (off != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = off[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   lane_wdata = {4{d[7:0]}};
            2'b01:   lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    // Pick the addressed lane out of the bus word and widen it per the latched sign mode.
    function automatic logic [31:0] load_extract(input logic [1:0] sz, input logic sext,
                                                 input logic [1:0] off, input logic [31:0] d);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (sz)
            2'b00:   r = sext ? 32'(b) : {24'd0, b};
            2'b01:   r = sext ? 32'(h) : {16'd0, h};
            default: r = d;
        endcase
        load_extract = r;
    endfunction

    assign misalign_c  = is_misaligned(size, addr[1:0]);
    assign wd_expire_c = (wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            wd_cnt <= '0;
        end else begin
            state  <= state_nx;
            wd_cnt <= (state == REQ && !dbus.bus_ready) ? wd_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        start_c  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    stall = 1'b1;
                    if (misalign_c) begin
                        state_nx = ERR;
                    end else begin
                        start_c  = 1'b1;
                        state_nx = REQ;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (dbus.bus_ready) begin
                    state_nx = RESP;
                end else if (wd_expire_c) begin
                    state_nx = ERR;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request issue: bus outputs are loaded once and held for the whole REQ phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbus.bus_valid <= 1'b0;
            dbus.bus_we    <= 1'b0;
            dbus.bus_addr  <= '0;
            dbus.bus_be    <= '0;
            dbus.bus_wdata <= '0;
            rdata          <= '0;
            err            <= 1'b0;
        end else begin
            err <= (state_nx == ERR);
            case (state)
                IDLE: begin
                    if (start_c) begin
                        dbus.bus_valid <= 1'b1;
                        dbus.bus_we    <= mem_we;
                        dbus.bus_addr  <= {addr[31:2], 2'b00};
                        dbus.bus_be    <= lane_be(size, addr[1:0]);
                        dbus.bus_wdata <= lane_wdata(size, wdata);
                    end
                end
                REQ: begin
                    if (dbus.bus_ready) begin
                        dbus.bus_valid <= 1'b0;
                        if (!dbus.bus_we) begin
                            rdata <= load_extract(size_p0, sext_p0, off_p0, dbus.bus_rdata);
                        end
                    end else if (wd_expire_c) begin
                        dbus.bus_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Load-format context, needed only when the response returns.
    always_ff @(posedge clk) begin
        if (start_c) begin
            size_p0 <= size;
            sext_p0 <= sign_ext;
            off_p0  <= addr[1:0];
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: reset, lane steering, load extension, errors, watchdog.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_access_unit_if dbus ();

    dmem_access_unit #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .err      (err),
        .dbus     (dbus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        mem_req        = 1'b0;
        dbus.bus_ready = 1'b0;
        tick();
    endtask

    // Issues one aligned access, answers after 'waits' REQ cycles, returns in the RESP cycle.
    task automatic access(input logic we, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, input int waits,
                          input logic [31:0] brd,
                          output logic [31:0] o_addr, output logic [3:0] o_be,
                          output logic [31:0] o_wdata, output logic o_we,
                          output int o_vcyc, output int o_stall, output logic o_stable);
        mem_req        = 1'b1;
        mem_we         = we;
        size           = sz;
        sign_ext       = sx;
        addr           = a;
        wdata          = wd;
        dbus.bus_ready = 1'b0;
        dbus.bus_rdata = brd;
        #1;
        o_stall  = stall ? 1 : 0;
        tick();
        o_addr   = dbus.bus_addr;
        o_be     = dbus.bus_be;
        o_wdata  = dbus.bus_wdata;
        o_we     = dbus.bus_we;
        o_vcyc   = 0;
        o_stable = 1'b1;
        for (int i = 0; i <= waits; i++) begin
            if (dbus.bus_valid) o_vcyc++;
            if (stall) o_stall++;
            if (dbus.bus_addr !== o_addr || dbus.bus_be !== o_be ||
                dbus.bus_wdata !== o_wdata || dbus.bus_we !== o_we) o_stable = 1'b0;
            if (i == waits) dbus.bus_ready = 1'b1;
            tick();
        end
        dbus.bus_ready = 1'b0;
    endtask

    logic [31:0] a_addr;
    logic [3:0]  a_be;
    logic [31:0] a_wdata;
    logic        a_we;
    int          a_vcyc;
    int          a_stall;
    logic        a_stable;
    int          to_cnt;
    logic        to_seen;

    initial begin
        #100000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst            = 1'b0;
        mem_req        = 1'b1;
        mem_we         = 1'b0;
        size           = 2'b10;
        sign_ext       = 1'b0;
        addr           = 32'h0000_0010;
        wdata          = 32'h0;
        dbus.bus_ready = 1'b1;
        dbus.bus_rdata = 32'hDEAD_BEEF;
        repeat (3) tick();

        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_valid", {31'd0, dbus.bus_valid}, 32'd0);
        check_eq("rst_we", {31'd0, dbus.bus_we}, 32'd0);
        check_eq("rst_addr", dbus.bus_addr, 32'h0);
        check_eq("rst_be", {28'd0, dbus.bus_be}, 32'h0);
        check_eq("rst_wdata", dbus.bus_wdata, 32'h0);
        check_eq("rst_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;

        access(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF,
               a_addr, a_be, a_wdata, a_we, a_vcyc, a_stall, a_stable);
        check_eq("wl_addr", a_addr, 32'h0000_0010);
        check_eq("wl_be", {28'd0, a_be}, 32'hF);
        check_eq("wl_we", {31'd0, a_we}, 32'd0);
        check_eq("wl_vcyc", a_vcyc, 32'd1);
        check_eq("wl_stall_cycles", a_stall, 32'd2);
        check_eq("wl_rdata", rdata, 32'hDEAD_BEEF);
        check_eq("wl_resp_stall", {31'd0, stall}, 32'd0);
        check_eq("wl_resp_valid", {31'd0, dbus.bus_valid}, 32'd0);
        go_idle();

        access(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, 0, 32'h8011_2233,
               a_addr, a_be, a_wdata, a_we, a_vcyc, a_stall, a_stable);
        check_eq("lb_s_be", {28'd0, a_be}, 32'h8);
        check_eq("lb_s_addr", a_addr, 32'h0000_0010);
        check_eq("lb_s_rdata", rdata, 32'hFFFF_FF80);
        go_idle();

        access(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h8011_2233,
               a_addr, a_be, a_wdata, a_we, a_vcyc, a_stall, a_stable);
        check_eq("lb_z_rdata", rdata, 32'h0000_0080);
        go_idle();

        access(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0, 0, 32'h8011_2233,
               a_addr, a_be, a_wdata, a_we, a_vcyc, a_stall, a_stable);
        check_eq("lh_s_be", {28'd0, a_be}, 32'hC);
        check_eq("lh_s_rdata", rdata, 32'hFFFF_8011);
        go_idle();

        access(1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_ABCD, 3, 32'h5555_5555,
               a_addr, a_be, a_wdata, a_we, a_vcyc, a_stall, a_stable);
        check_eq("sh_we", {31'd0, a_we}, 32'd1);
        check_eq("sh_be", {28'd0, a_be}, 32'hC);
        check_eq("sh_addr", a_addr, 32'h0000_0020);
        check_eq("sh_wdata", a_wdata, 32'hABCD_ABCD);
        check_eq("sh_vcyc", a_vcyc, 32'd4);
        check_eq("sh_stable", {31'd0, a_stable}, 32'd1);
        check_eq("sh_stall_cycles", a_stall, 32'd5);
        check_eq("sh_rdata_kept", rdata, 32'hFFFF_8011);
        go_idle();

        mem_req = 1'b1;
        mem_we  = 1'b0;
        size    = 2'b10;
        addr    = 32'h0000_0021;
        #1;
        check_eq("mis_stall_c0", {31'd0, stall}, 32'd1);
        tick();
        check_eq("mis_err", {31'd0, err}, 32'd1);
        check_eq("mis_valid", {31'd0, dbus.bus_valid}, 32'd0);
        check_eq("mis_stall_err", {31'd0, stall}, 32'd0);
        check_eq("mis_rdata_kept", rdata, 32'hFFFF_8011);
        go_idle();
        check_eq("mis_err_clear", {31'd0, err}, 32'd0);

        mem_req = 1'b1;
        size    = 2'b11;
        addr    = 32'h0000_0020;
        tick();
        check_eq("ill_err", {31'd0, err}, 32'd1);
        check_eq("ill_valid", {31'd0, dbus.bus_valid}, 32'd0);
        go_idle();
        check_eq("ill_err_clear", {31'd0, err}, 32'd0);

        mem_req        = 1'b1;
        size           = 2'b10;
        addr           = 32'h0000_0030;
        dbus.bus_ready = 1'b0;
        tick();
        mem_req = 1'b0;
        to_cnt  = 0;
        to_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (dbus.bus_valid) to_cnt++;
            if (err) begin
                to_seen = 1'b1;
                break;
            end
            tick();
        end
        check_eq("to_valid_cycles", to_cnt, 32'd4);
        check_eq("to_err_seen", {31'd0, to_seen}, 32'd1);
        check_eq("to_stall_err", {31'd0, stall}, 32'd0);
        check_eq("to_rdata_kept", rdata, 32'hFFFF_8011);
        tick();
        check_eq("to_err_clear", {31'd0, err}, 32'd0);
        check_eq("to_valid_idle", {31'd0, dbus.bus_valid}, 32'd0);

        dbus.bus_ready = 1'b1;
        tick();
        check_eq("stray_ready_valid", {31'd0, dbus.bus_valid}, 32'd0);
        check_eq("stray_ready_stall", {31'd0, stall}, 32'd0);

        access(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h1234_5678,
               a_addr, a_be, a_wdata, a_we, a_vcyc, a_stall, a_stable);
        check_eq("post_to_vcyc", a_vcyc, 32'd2);
        check_eq("post_to_rdata", rdata, 32'h1234_5678);
        go_idle();

        mem_req        = 1'b1;
        size           = 2'b10;
        addr           = 32'h0000_0050;
        dbus.bus_ready = 1'b0;
        tick();
        check_eq("rstreq_valid_before", {31'd0, dbus.bus_valid}, 32'd1);
        rst = 1'b0;
        #1;
        check_eq("rstreq_valid_after", {31'd0, dbus.bus_valid}, 32'd0);
        check_eq("rstreq_stall", {31'd0, stall}, 32'd1);
        check_eq("rstreq_rdata", rdata, 32'h0);
        #1;
        rst     = 1'b1;
        mem_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
